// File: rtl/wb_bus_guard.sv
// Wishbone classic watchdog: zero-latency pass-through that aborts a stalled slave cycle after TIMEOUT cycles.
// Optional macro WB_GUARD_RDT_POISON_EN returns POISON as read data on a timed-out read.
module wb_bus_guard #(
    parameter int          AW      = 12,
    parameter int          TIMEOUT = 64,
    parameter int          CNTW    = 8,
    parameter logic [31:0] POISON  = 32'hDEADBEEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-3:0]   i_m_adr,
    input  logic [31:0]     i_m_dat,
    input  logic [3:0]      i_m_sel,
    input  logic            i_m_we,
    input  logic            i_m_cyc,
    input  logic            i_m_stb,
    output logic [31:0]     o_m_rdt,
    output logic            o_m_ack,
    output logic            o_m_err,
    output logic [AW-3:0]   o_s_adr,
    output logic [31:0]     o_s_dat,
    output logic [3:0]      o_s_sel,
    output logic            o_s_we,
    output logic            o_s_cyc,
    output logic            o_s_stb,
    input  logic [31:0]     i_s_rdt,
    input  logic            i_s_ack,
    input  logic            i_s_err,
    input  logic            i_irq_clr,
    output logic            o_irq,
    output logic [AW-3:0]   o_fault_adr,
    output logic            o_fault_we,
    output logic [CNTW-1:0] o_fault_cnt,
    output logic [1:0]      o_dbg_state
);

    // Handshake: a master access is cyc&stb held until ack or err; the guard either
    // forwards the slave's ack/err in the same cycle or substitutes a single-cycle err.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_q, irq_d;
    logic [AW-3:0]   fadr_q, fadr_d;
    logic            fwe_q, fwe_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic            slv_resp;

    assign slv_resp = i_s_ack | i_s_err;

    assign o_s_adr     = i_m_adr;
    assign o_s_dat     = i_m_dat;
    assign o_s_sel     = i_m_sel;
    assign o_s_we      = i_m_we;
    assign o_irq       = irq_q;
    assign o_fault_adr = fadr_q;
    assign o_fault_we  = fwe_q;
    assign o_fault_cnt = fcnt_q;
    assign o_dbg_state = state_q;

`ifdef WB_GUARD_RDT_POISON_EN
    assign o_m_rdt = (state_q == ABORT && !i_m_we) ? POISON : i_s_rdt;
`else
    logic [31:0] unused_poison;
    assign unused_poison = POISON;
    assign o_m_rdt       = i_s_rdt;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q & ~i_irq_clr;
        fadr_d  = fadr_q;
        fwe_d   = fwe_q;
        fcnt_d  = fcnt_q;
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_m_ack = 1'b0;
        o_m_err = 1'b0;

        case (state_q)
            IDLE: begin
                o_s_cyc = i_m_cyc;
                o_s_stb = i_m_stb;
                o_m_ack = i_s_ack;
                o_m_err = i_s_err;
                if (i_m_cyc && i_m_stb && !slv_resp) begin
                    state_d = ACTIVE;
                    cnt_d   = CW'(1);
                end
            end
            ACTIVE: begin
                o_s_cyc = i_m_cyc;
                o_s_stb = i_m_stb;
                o_m_ack = i_s_ack;
                o_m_err = i_s_err;
                // A master that drops cyc without a response simply abandons the access.
                if (slv_resp || !i_m_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ABORT: begin
                o_m_err = 1'b1;
                fadr_d  = i_m_adr;
                fwe_d   = i_m_we;
                irq_d   = 1'b1;
                if (fcnt_q != {CNTW{1'b1}}) begin
                    fcnt_d = fcnt_q + CNTW'(1);
                end
                state_d = i_m_cyc ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!i_m_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset drops the slave cycle and any response in the same cycle.
        if (i_rst) begin
            o_s_cyc = 1'b0;
            o_s_stb = 1'b0;
            o_m_ack = 1'b0;
            o_m_err = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            fadr_q  <= '0;
            fwe_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            fadr_q  <= fadr_d;
            fwe_q   <= fwe_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_guard.sv
// Bench for wb_bus_guard: directed accesses, response scoreboard, fault-register checks.
module tb_wb_bus_guard;

    localparam int TIMEOUT = 8;
    localparam int AW      = 12;
    localparam int CNTW    = 8;
`ifdef WB_GUARD_RDT_POISON_EN
    localparam bit POISON_ON = 1'b1;
`else
    localparam bit POISON_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-3:0]   m_adr;
    logic [31:0]     m_dat;
    logic [3:0]      m_sel;
    logic            m_we, m_cyc, m_stb;
    logic [31:0]     m_rdt;
    logic            m_ack, m_err;
    logic [AW-3:0]   s_adr;
    logic [31:0]     s_dat;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb;
    logic [31:0]     s_rdt;
    logic            s_ack, s_err;
    logic            irq_clr, irq;
    logic [AW-3:0]   fault_adr;
    logic            fault_we;
    logic [CNTW-1:0] fault_cnt;
    logic [1:0]      dbg_state;

    // Scoreboard entry: {check_rdt, ack, err, rdt}
    logic [34:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    int           exp_cnt  = 0;
    logic         exp_irq  = 1'b0;
    logic [9:0]   exp_fadr = '0;
    logic         exp_fwe  = 1'b0;

    wb_bus_guard #(.AW(AW), .TIMEOUT(TIMEOUT), .CNTW(CNTW), .POISON(32'hDEADBEEF)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb),
        .o_m_rdt(m_rdt), .o_m_ack(m_ack), .o_m_err(m_err),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .i_s_err(s_err),
        .i_irq_clr(irq_clr), .o_irq(irq),
        .o_fault_adr(fault_adr), .o_fault_we(fault_we), .o_fault_cnt(fault_cnt),
        .o_dbg_state(dbg_state)
    );

    // Clock / time bound
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        logic [34:0] item;
        if (m_ack || m_err) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b, expected no response", m_ack, m_err);
            end else begin
                item = exp_q.pop_front();
                chk("resp_ack", 32'(m_ack), 32'(item[33]));
                chk("resp_err", 32'(m_err), 32'(item[32]));
                if (item[34]) chk("resp_rdt", m_rdt, item[31:0]);
            end
        end
    end

    task automatic check_fault_regs(input string tag);
        chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(exp_cnt));
        chk({tag, "_fault_adr"}, 32'(fault_adr), 32'(exp_fadr));
        chk({tag, "_fault_we"},  32'(fault_we),  32'(exp_fwe));
        chk({tag, "_irq"},       32'(irq),       32'(exp_irq));
    endtask

    // One master access; resp_at < 0 means the slave never answers.
    task automatic access(input logic [9:0] adr, input logic we, input logic [31:0] wdat,
                          input int resp_at, input logic resp_err, input logic [31:0] rdt,
                          input logic late_ack, input logic clr_in_abort);
        int last;
        last  = (resp_at >= 0) ? resp_at : TIMEOUT;
        m_adr = adr; m_we = we; m_dat = wdat; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        for (int c = 0; c <= last; c++) begin
            s_ack = 1'b0; s_err = 1'b0; s_rdt = rdt; irq_clr = 1'b0;
            if (c == resp_at) begin
                if (resp_err) s_err = 1'b1;
                else          s_ack = 1'b1;
                exp_q.push_back({!we && !resp_err, !resp_err, resp_err, rdt});
            end
            if (resp_at < 0 && c == TIMEOUT) begin
                s_ack   = late_ack;
                irq_clr = clr_in_abort;
                exp_q.push_back({POISON_ON && !we, 1'b0, 1'b1, 32'hDEADBEEF});
            end
            @(negedge clk);
            if (resp_at < 0) chk("s_stb", 32'(s_stb), 32'(c < TIMEOUT));
            @(posedge clk); #1;
        end
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0; s_err = 1'b0; irq_clr = 1'b0;
        @(negedge clk);
        chk("resp_pending", 32'(exp_q.size()), 32'd0);
        if (resp_at < 0) begin
            exp_fadr = adr;
            exp_fwe  = we;
            if (exp_cnt < 255) exp_cnt++;
            exp_irq  = 1'b1;
            chk("state_drain", 32'(dbg_state), 32'd3);
        end else begin
            chk("state_idle", 32'(dbg_state), 32'd0);
        end
        check_fault_regs("post");
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; irq_clr = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        s_rdt = 32'h0; s_ack = 1'b1; s_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        check_fault_regs("rst");
        @(posedge clk); #1;
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0;
        @(posedge clk); #1;

        // Read acked at cycle 3
        access(10'h010, 1'b0, 32'h0, 3, 1'b0, 32'h12345678, 1'b0, 1'b0);
        // Write timeout
        access(10'h3F0, 1'b1, 32'hA5A5A5A5, -1, 1'b0, 32'h0, 1'b0, 1'b0);
        // Read timeout, late ack swallowed, irq clear collides with abort
        access(10'h055, 1'b0, 32'h0, -1, 1'b0, 32'h0BADF00D, 1'b1, 1'b1);
        // Later clear drops irq
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        exp_irq = 1'b0;
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);
        @(posedge clk); #1;
        // Ack at last allowed cycle, then ack in cycle 0
        access(10'h111, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
        access(10'h222, 1'b1, 32'h1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Slave err forwarded
        access(10'h0AA, 1'b0, 32'h0, 2, 1'b1, 32'h55AA55AA, 1'b0, 1'b0);

        // Master abandons at cycle 4
        m_adr = 10'h077; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("abandon_s_cyc", 32'(s_cyc), 32'd0);
        repeat (TIMEOUT + 2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("abandon_state", 32'(dbg_state), 32'd0);
        check_fault_regs("abandon");
        @(posedge clk); #1;

        // Reset at cycle 2 of an active access
        m_adr = 10'h199; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_cyc", 32'(s_cyc), 32'd0);
        chk("midrst_s_stb", 32'(s_stb), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        exp_cnt = 0; exp_irq = 1'b0; exp_fadr = '0; exp_fwe = 1'b0;
        @(negedge clk);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        check_fault_regs("midrst");
        @(posedge clk); #1;

        // Saturation of the fault counter
        for (int i = 0; i < 258; i++) begin
            access(10'(i * 7), 1'(i % 2), 32'(i), -1, 1'b0, 32'(i), 1'b0, 1'b0);
        end
        chk("sat_cnt", 32'(fault_cnt), 32'hFF);

        repeat (3) @(posedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
